smi_rx_mc: RTL and testbench

SMI_RX_MC -- requirements
Module: smi_rx_mc

---
 rtl/smi_rx_mc_pkg.sv | 28 ++
 rtl/smi_rx_mc_if.sv | 28 ++
 rtl/smi_rx_mc_strobe_sync.sv | 42 ++++
 rtl/smi_rx_mc.sv | 150 +++++++++++++++
 tb/tb_smi_rx_mc.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/smi_rx_mc_pkg.sv
// Shared constants for the SMI receive deframer: state codes, header bit
// positions and the bus-width to beats-per-sample relationship.
package smi_pkg;

    // Deframer states (one per byte lane of the 32-bit sample)
    localparam logic [1:0] S_B0 = 2'd0;
    localparam logic [1:0] S_B1 = 2'd1;
    localparam logic [1:0] S_B2 = 2'd2;
    localparam logic [1:0] S_B3 = 2'd3;

    // byte0 (header) bit positions
    localparam int HDR_START  = 0;
    localparam int HDR_CH_LSB = 1;
    localparam int HDR_CH_W   = 2;
    localparam int HDR_COND   = 5;
    localparam int HDR_MODEM  = 6;

    // byte2 bit0 must be clear; a set bit there marks a new header
    localparam int B2_MARK    = 0;

    localparam int WORD_W     = 32;

    // Bus beats that make up one 32-bit sample
    function automatic int beats_per_word(input int bus_w);
        return WORD_W / bus_w;
    endfunction

endpackage

// File: rtl/smi_rx_mc_if.sv
// SMI write bus plus the per-channel FIFO push side of the receiver.
interface smi_rx_mc_if #(
    parameter int BUS_W  = 8,
    parameter int NUM_CH = 2
);
    logic              i_smi_swe_srw;
    logic [BUS_W-1:0]  i_smi_data_in;
    logic              o_smi_write_req;
    logic [NUM_CH-1:0] i_fifo_full;
    logic [NUM_CH-1:0] o_fifo_push;
    logic [31:0]       o_fifo_data;
    logic [NUM_CH-1:0] o_modem_ctrl;
    logic [NUM_CH-1:0] o_cond_ctrl;

    // Receiver side
    modport slave (
        input  i_smi_swe_srw, i_smi_data_in, i_fifo_full,
        output o_smi_write_req, o_fifo_push, o_fifo_data,
               o_modem_ctrl, o_cond_ctrl
    );

    // Host / FIFO side
    modport master (
        output i_smi_swe_srw, i_smi_data_in, i_fifo_full,
        input  o_smi_write_req, o_fifo_push, o_fifo_data,
               o_modem_ctrl, o_cond_ctrl
    );
endinterface

// File: rtl/smi_rx_mc_strobe_sync.sv
// Brings the asynchronous SMI write strobe into the system clock domain and
// emits a one-cycle capture pulse with the data word seen at the strobe fall.
module smi_strobe_sync #(
    parameter int W = 8
) (
    input  logic         i_sys_clk,
    input  logic         swe_and_reset,
    input  logic         swe,
    input  logic [W-1:0] din,
    output logic         cap_vld,
    output logic [W-1:0] cap_data
);
    // s[0],s[1]: synchroniser; s[2]: previous synchronised level
    logic [2:0]   s;
    logic [W-1:0] d1, d2;

    // Strobe synchroniser with the data riding alongside; idle-high reset
    // keeps reset release from looking like a falling edge
    always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
        if (!swe_and_reset) begin
            s  <= 3'b111;
            d1 <= '0;
            d2 <= '0;
        end else begin
            s  <= {s[1:0], swe};
            d1 <= din;
            d2 <= d1;
        end
    end

    // Falling-edge detect registered together with the matching data word
    always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
        if (!swe_and_reset) begin
            cap_vld  <= 1'b0;
            cap_data <= '0;
        end else begin
            cap_vld  <= s[2] & ~s[1];
            cap_data <= d2;
        end
    end

endmodule

// File: rtl/smi_rx_mc.sv
// SMI receive deframer: assembles 32-bit samples from SMI writes, checks the
// header/sync markers and pushes each sample into its channel FIFO.
module smi_rx_mc
    import smi_pkg::*;
#(
    parameter int BUS_W  = 8,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic             i_sys_clk,
    input  logic             swe_and_reset,
    smi_rx_mc_if.slave       bus,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_sync_err_cnt,
    output logic [CNT_W-1:0] o_ovf_cnt
);
    localparam int BEATS = beats_per_word(BUS_W);
    // state after an accepted header beat
    localparam logic [1:0] S_AFTER_HDR = (BEATS == 2) ? S_B2 : S_B1;

    logic             cap_vld;
    logic [BUS_W-1:0] cap_data;
    logic [1:0]       state, state_nxt;
    logic [31:0]      asm_q, asm_nxt;
    logic             done, hdr_err;
    logic [1:0]       ch;
    logic             ch_ok;
    logic [3:0]       full_pad, ch_oh;
    logic             push_ok, sync_inc, ovf_inc;

    smi_strobe_sync #(.W(BUS_W)) u_sync (
        .i_sys_clk     (i_sys_clk),
        .swe_and_reset (swe_and_reset),
        .swe           (bus.i_smi_swe_srw),
        .din           (bus.i_smi_data_in),
        .cap_vld       (cap_vld),
        .cap_data      (cap_data)
    );

    // Deframer next state and assembly register update, one beat at a time
    always_comb begin
        state_nxt = state;
        asm_nxt   = asm_q;
        done      = 1'b0;
        hdr_err   = 1'b0;
        if (cap_vld) begin
            case (state)
                S_B0: begin
                    if (cap_data[HDR_START]) begin
                        asm_nxt[BUS_W-1:0] = cap_data;
                        state_nxt          = S_AFTER_HDR;
                    end else begin
                        hdr_err = 1'b1;
                    end
                end
                S_B1: begin
                    asm_nxt[15:8] = cap_data[7:0];
                    state_nxt     = S_B2;
                end
                S_B2: begin
                    if (!cap_data[B2_MARK]) begin
                        asm_nxt[16 +: BUS_W] = cap_data;
                        if (BEATS == 2) begin
                            done      = 1'b1;
                            state_nxt = S_B0;
                        end else begin
                            state_nxt = S_B3;
                        end
                    end else begin
                        // lost alignment: this beat is the next header
                        hdr_err            = 1'b1;
                        asm_nxt[BUS_W-1:0] = cap_data;
                        state_nxt          = S_AFTER_HDR;
                    end
                end
                S_B3: begin
                    asm_nxt[31:24] = cap_data[7:0];
                    done           = 1'b1;
                    state_nxt      = S_B0;
                end
                default: state_nxt = S_B0;
            endcase
        end
    end

    // Channel routing and drop decisions for a completed sample
    always_comb begin
        full_pad               = '0;
        full_pad[NUM_CH-1:0]   = bus.i_fifo_full;
        ch                     = asm_nxt[HDR_CH_LSB +: HDR_CH_W];
        ch_ok                  = int'(ch) < NUM_CH;
        ch_oh                  = 4'b0001 << ch;
        push_ok                = done & ch_ok & ~full_pad[ch];
        ovf_inc                = done & ch_ok &  full_pad[ch];
        sync_inc               = hdr_err | (done & ~ch_ok);
    end

    // FSM state and shared assembly register
    always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
        if (!swe_and_reset) begin
            state <= S_B0;
            asm_q <= '0;
        end else begin
            state <= state_nxt;
            asm_q <= asm_nxt;
        end
    end

    // Push strobe, sample data and control flags; full is judged in the
    // completing cycle so the push leaves a flop cleanly
    always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
        if (!swe_and_reset) begin
            bus.o_fifo_push  <= '0;
            bus.o_fifo_data  <= '0;
            bus.o_modem_ctrl <= '0;
            bus.o_cond_ctrl  <= '0;
        end else begin
            bus.o_fifo_push <= '0;
            if (push_ok) begin
                bus.o_fifo_push  <= ch_oh[NUM_CH-1:0];
                bus.o_fifo_data  <= asm_nxt;
                bus.o_modem_ctrl <= (bus.o_modem_ctrl & ~ch_oh[NUM_CH-1:0]) |
                                    (ch_oh[NUM_CH-1:0] & {NUM_CH{asm_nxt[HDR_MODEM]}});
                bus.o_cond_ctrl  <= (bus.o_cond_ctrl & ~ch_oh[NUM_CH-1:0]) |
                                    (ch_oh[NUM_CH-1:0] & {NUM_CH{asm_nxt[HDR_COND]}});
            end
        end
    end

    // Host may write only while every channel FIFO has room
    always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
        if (!swe_and_reset) bus.o_smi_write_req <= 1'b0;
        else                bus.o_smi_write_req <= ~|bus.i_fifo_full;
    end

    // Sync error counter: saturating, clear has priority
    always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
        if (!swe_and_reset)                      o_sync_err_cnt <= '0;
        else if (i_cnt_clr)                      o_sync_err_cnt <= '0;
        else if (sync_inc && !(&o_sync_err_cnt)) o_sync_err_cnt <= o_sync_err_cnt + 1'b1;
    end

    // Overflow counter: saturating, clear has priority
    always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
        if (!swe_and_reset)                o_ovf_cnt <= '0;
        else if (i_cnt_clr)                o_ovf_cnt <= '0;
        else if (ovf_inc && !(&o_ovf_cnt)) o_ovf_cnt <= o_ovf_cnt + 1'b1;
    end

endmodule

// File: tb/tb_smi_rx_mc.sv
// Directed bench for smi_rx_mc: 8-bit default build, 16-bit build and a
// 2-bit counter build, each on its own bus and reset.
module tb_smi_rx_mc;
    import smi_pkg::*;

    logic clk;
    logic rst8, rst16, rstc;
    logic clr8, clr16, clrc;
    logic [15:0] sync8, ovf8, sync16, ovf16;
    logic [1:0]  syncc, ovfc;

    int total = 0;
    int bad   = 0;
    int pc8 [2];
    int pc16[2];
    int pcc [2];
    logic [31:0] dat8, dat16;

    smi_rx_mc_if #(.BUS_W(8),  .NUM_CH(2)) bus8  ();
    smi_rx_mc_if #(.BUS_W(16), .NUM_CH(2)) bus16 ();
    smi_rx_mc_if #(.BUS_W(8),  .NUM_CH(2)) busc  ();

    smi_rx_mc #(.BUS_W(8), .NUM_CH(2), .CNT_W(16)) u8 (
        .i_sys_clk(clk), .swe_and_reset(rst8), .bus(bus8),
        .i_cnt_clr(clr8), .o_sync_err_cnt(sync8), .o_ovf_cnt(ovf8));
    smi_rx_mc #(.BUS_W(16), .NUM_CH(2), .CNT_W(16)) u16 (
        .i_sys_clk(clk), .swe_and_reset(rst16), .bus(bus16),
        .i_cnt_clr(clr16), .o_sync_err_cnt(sync16), .o_ovf_cnt(ovf16));
    smi_rx_mc #(.BUS_W(8), .NUM_CH(2), .CNT_W(2)) uc (
        .i_sys_clk(clk), .swe_and_reset(rstc), .bus(busc),
        .i_cnt_clr(clrc), .o_sync_err_cnt(syncc), .o_ovf_cnt(ovfc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // push monitors: count pulses per channel, keep last pushed word
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (bus8.o_fifo_push[c])  pc8[c]  <= pc8[c] + 1;
            if (bus16.o_fifo_push[c]) pc16[c] <= pc16[c] + 1;
            if (busc.o_fifo_push[c])  pcc[c]  <= pcc[c] + 1;
        end
        if (|bus8.o_fifo_push)  dat8  <= bus8.o_fifo_data;
        if (|bus16.o_fifo_push) dat16 <= bus16.o_fifo_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one SMI write: strobe low 3 clocks, high at least 3 clocks
    task automatic send(input int which, input logic [15:0] v);
        @(posedge clk); #1;
        case (which)
            0: begin bus8.i_smi_data_in  = v[7:0]; bus8.i_smi_swe_srw  = 1'b0; end
            1: begin bus16.i_smi_data_in = v;      bus16.i_smi_swe_srw = 1'b0; end
            default: begin busc.i_smi_data_in = v[7:0]; busc.i_smi_swe_srw = 1'b0; end
        endcase
        repeat (3) @(posedge clk); #1;
        bus8.i_smi_swe_srw  = 1'b1;
        bus16.i_smi_swe_srw = 1'b1;
        busc.i_smi_swe_srw  = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic send4(input logic [7:0] b0, b1, b2, b3);
        send(0, {8'h0, b0}); send(0, {8'h0, b1});
        send(0, {8'h0, b2}); send(0, {8'h0, b3});
    endtask

    task automatic settle();
        repeat (6) @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        bad++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        pc8 = '{0, 0}; pc16 = '{0, 0}; pcc = '{0, 0};
        dat8 = '0; dat16 = '0;
        rst8 = 1'b0; rst16 = 1'b0; rstc = 1'b0;
        clr8 = 1'b0; clr16 = 1'b0; clrc = 1'b0;
        bus8.i_smi_swe_srw = 1'b1;  bus8.i_smi_data_in = '0;  bus8.i_fifo_full = '0;
        bus16.i_smi_swe_srw = 1'b1; bus16.i_smi_data_in = '0; bus16.i_fifo_full = '0;
        busc.i_smi_swe_srw = 1'b1;  busc.i_smi_data_in = '0;  busc.i_fifo_full = '0;

        // reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_wreq",  32'(bus8.o_smi_write_req), 32'h0);
        chk("rst_push",  32'(bus8.o_fifo_push),     32'h0);
        chk("rst_data",  bus8.o_fifo_data,          32'h0);
        chk("rst_ctrl",  32'({bus8.o_modem_ctrl, bus8.o_cond_ctrl}), 32'h0);
        chk("rst_sync",  32'(sync8), 32'h0);
        chk("rst_ovf",   32'(ovf8),  32'h0);
        chk("rst_state", 32'(u8.state), 32'(S_B0));
        rst8 = 1'b1; rst16 = 1'b1; rstc = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("wreq_idle", 32'(bus8.o_smi_write_req), 32'h1);
        chk("no_spur_push", 32'(pc8[0] + pc8[1]), 32'h0);

        // basic ch0 frame, modem flag set
        send4(8'h41, 8'h22, 8'h32, 8'h44);
        settle();
        chk("f0_push0", 32'(pc8[0]), 32'h1);
        chk("f0_push1", 32'(pc8[1]), 32'h0);
        chk("f0_data",  dat8,        32'h44322241);
        chk("f0_modem", 32'(bus8.o_modem_ctrl), 32'h1);
        chk("f0_cond",  32'(bus8.o_cond_ctrl),  32'h0);
        chk("f0_sync",  32'(sync8), 32'h0);

        // missing start marker, then a ch1 frame with cond flag
        send(0, 16'h0040);
        send4(8'h23, 8'h11, 8'h10, 8'h99);
        settle();
        chk("nohdr_sync", 32'(sync8),  32'h1);
        chk("ch1_push",   32'(pc8[1]), 32'h1);
        chk("ch1_push0",  32'(pc8[0]), 32'h1);
        chk("ch1_data",   dat8,        32'h99101123);
        chk("ch1_ctrl",   32'({bus8.o_modem_ctrl, bus8.o_cond_ctrl}), 32'b0110);

        // marker in byte2 resyncs: 0x03 becomes ch1 header
        send(0, 16'h0001); send(0, 16'h0055); send(0, 16'h0003);
        send(0, 16'h00AA); send(0, 16'h0000);
        settle();
        chk("resync_sync",   32'(sync8),  32'h2);
        chk("resync_nopush", 32'(pc8[1]), 32'h1);
        send(0, 16'h0077);
        settle();
        chk("resync_push", 32'(pc8[1]), 32'h2);
        chk("resync_data", dat8,        32'h7700AA03);
        chk("resync_cond", 32'(bus8.o_cond_ctrl), 32'h0);

        // channel id 2 is out of range for two channels
        send4(8'h05, 8'h00, 8'h00, 8'h00);
        settle();
        chk("badch_sync", 32'(sync8), 32'h3);
        chk("badch_push", 32'(pc8[0] + pc8[1]), 32'h3);

        // ch1 FIFO full: three samples dropped
        bus8.i_fifo_full = 2'b10;
        repeat (2) @(posedge clk); #1;
        chk("full_wreq", 32'(bus8.o_smi_write_req), 32'h0);
        for (int i = 0; i < 3; i++) send4(8'h03, 8'h01, 8'h02, 8'h03);
        settle();
        chk("full_ovf",  32'(ovf8),   32'h3);
        chk("full_push", 32'(pc8[1]), 32'h2);
        bus8.i_fifo_full = 2'b00;
        repeat (2) @(posedge clk); #1;
        chk("unfull_wreq", 32'(bus8.o_smi_write_req), 32'h1);

        // counter clear
        clr8 = 1'b1; @(posedge clk); #1; clr8 = 1'b0;
        chk("clr_sync", 32'(sync8), 32'h0);
        chk("clr_ovf",  32'(ovf8),  32'h0);

        // reset mid-sample discards the partial frame
        send(0, 16'h0041); send(0, 16'h0022);
        rst8 = 1'b0; repeat (2) @(posedge clk); #1;
        chk("mid_rst_state", 32'(u8.state), 32'(S_B0));
        rst8 = 1'b1;
        send4(8'h41, 8'h22, 8'h32, 8'h44);
        settle();
        chk("mid_rst_push", 32'(pc8[0]), 32'h2);
        chk("mid_rst_data", dat8,        32'h44322241);
        chk("mid_rst_sync", 32'(sync8),  32'h0);

        // 16-bit bus
        send(1, 16'h0101); send(1, 16'h0200);
        settle();
        chk("w16_push", 32'(pc16[0]), 32'h1);
        chk("w16_data", dat16,        32'h02000101);
        send(1, 16'h0101);
        rst16 = 1'b0; repeat (2) @(posedge clk); #1;
        chk("w16_rst_state", 32'(u16.state), 32'(S_B0));
        rst16 = 1'b1;
        send(1, 16'h0200);
        settle();
        chk("w16_rst_push", 32'(pc16[0] + pc16[1]), 32'h1);
        chk("w16_rst_sync", 32'(sync16), 32'h1);

        // 2-bit counter saturates
        for (int i = 0; i < 5; i++) send(2, 16'h0000);
        settle();
        chk("sat_sync", 32'(syncc), 32'h3);

        // clear in the same cycle as an increment: capture lands 3 edges
        // after the strobe fall is first sampled
        @(posedge clk); #1;
        busc.i_smi_data_in = 8'h00; busc.i_smi_swe_srw = 1'b0;
        repeat (3) @(posedge clk); #1;
        busc.i_smi_swe_srw = 1'b1;
        clrc = 1'b1;
        @(posedge clk); #1;
        clrc = 1'b0;
        chk("clr_win", 32'(syncc), 32'h0);
        send(2, 16'h0000);
        settle();
        chk("after_clr", 32'(syncc), 32'h1);
        chk("uc_nopush", 32'(pcc[0] + pcc[1]), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
